// File: rtl/dcache_pkg.sv
// Shared types for the L1 data-cache miss path: MESI line states, bus
// commands, miss-handler FSM states and line geometry.
package dcache_pkg;

   localparam int LINE_BITS   = 256;
   localparam int WORD_BITS   = 32;
   localparam int BEATS       = LINE_BITS / WORD_BITS;
   localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);

   // MESI state of a cache line, as seen by the cache refill logic
   typedef enum logic [3:0] {
      Invalid   = 4'd0,
      Shared    = 4'd1,
      Exclusive = 4'd2,
      Modified  = 4'd3
   } lineStage;

   typedef enum logic [1:0] {
      BusRd   = 2'd0,
      BusRdX  = 2'd1,
      BusUpgr = 2'd2,
      BusWB   = 2'd3
   } bus_cmd_e;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WB_REQ   = 3'd1,
      WB_DATA  = 3'd2,
      RD_REQ   = 3'd3,
      RD_DATA  = 3'd4,
      UPG_REQ  = 3'd5,
      UPG_WAIT = 3'd6,
      DONE     = 3'd7
   } missState;

   // State the refilled line takes once the transaction has finished.
   // Any write intent (write miss or upgrade) ends in Modified; a clean read
   // ends in Shared if any snooper claimed the line, Exclusive otherwise.
   function automatic lineStage finalStage(input logic isWrite,
                                           input logic isUpgrade,
                                           input logic sharedSeen,
                                           input logic aborted);
      if (aborted)
         return Invalid;
      else if (isWrite || isUpgrade)
         return Modified;
      else if (sharedSeen)
         return Shared;
      else
         return Exclusive;
   endfunction

endpackage

// File: rtl/dcache_line_buf.sv
// Beat-indexed line assembly buffer: one word written per read beat, whole
// line presented in parallel for the refill. Cleared at the start of a miss
// so a new fill never carries words from an earlier one.
module dcache_line_buf #(
   parameter int WordSize = 32,
   parameter int Beats    = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         wrEn,
   input  logic [$clog2(Beats)-1:0]     wrIdx,
   input  logic [WordSize-1:0]          wrData,
   output logic [Beats*WordSize-1:0]    line
);

   logic [WordSize-1:0] words [Beats];

   // Word storage: async clear on reset, sync clear per miss, beat write
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < Beats; i++) words[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < Beats; i++) words[i] <= '0;
      end else if (wrEn) begin
         words[wrIdx] <= wrData;
      end
   end

   // Pack the words into the flat line, beat 0 in the low word
   always_comb begin
      line = '0;
      for (int i = 0; i < Beats; i++) line[i*WordSize +: WordSize] = words[i];
   end

endmodule

// File: rtl/dcache_miss_unit.sv
// Miss/coherence handler behind the MESI L1 data cache. Per miss it may
// write back a dirty victim (BusWB), then fetches the line (BusRd/BusRdX)
// or only upgrades ownership (BusUpgr), and hands the line plus its final
// MESI state back to the cache for one cycle.
module dcache_miss_unit
   import dcache_pkg::*;
#(
   parameter int AddressSize = 32,
   parameter int WordSize    = 32,
   parameter int LineBits    = 256
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   miss_req_i,
   input  logic                   miss_write_i,
   input  logic                   miss_upgrade_i,
   input  logic [AddressSize-1:0] miss_addr_i,
   input  logic                   victim_dirty_i,
   input  logic [AddressSize-1:0] victim_addr_i,
   input  logic [LineBits-1:0]    victim_data_i,
   output logic                   miss_busy_o,
   output logic                   miss_done_o,
   output logic [LineBits-1:0]    fill_data_o,
   output logic [3:0]             fill_state_o,
   output logic                   fill_has_data_o,
   output logic                   bus_req_o,
   input  logic                   bus_gnt_i,
   output logic [1:0]             bus_cmd_o,
   output logic [AddressSize-1:0] bus_addr_o,
   output logic [WordSize-1:0]    bus_wdata_o,
   input  logic                   bus_wready_i,
   input  logic                   bus_rvalid_i,
   input  logic [WordSize-1:0]    bus_rdata_i,
   input  logic                   bus_shared_i,
   input  logic                   bus_ack_i,
   input  logic                   bus_err_i
);

   localparam int Beats      = LineBits / WordSize;
   localparam int BeatBits   = $clog2(Beats);
   localparam int OffsetBits = $clog2(LineBits / 8);
   localparam int ByteBits   = $clog2(WordSize / 8);

   missState                     state, nextState;
   logic [BeatBits-1:0]          beat;
   logic                         writeQ, upgradeQ, sharedSeen, abortedQ;
   logic [AddressSize-1:0]       missAddrQ, victimAddrQ;
   logic [LineBits-1:0]          victimDataQ;
   logic [LineBits-1:0]          lineData;

   logic                         accept, errAbort, lastBeat;
   logic                         wbBeat, rdBeat, hasData;
   int                           beatIdx;
   logic [AddressSize-1:0]       missBase, victimBase, beatOffset;
   bus_cmd_e                     rdCmd;

   // Offset bits are dropped on purpose: every transfer is line aligned
   logic                         unusedOffsetBits;
   assign unusedOffsetBits = ^{missAddrQ[OffsetBits-1:0], victimAddrQ[OffsetBits-1:0]};

   assign accept     = (state == IDLE) && miss_req_i;
   assign errAbort   = bus_err_i && (state != IDLE) && (state != DONE);
   assign lastBeat   = (beat == BeatBits'(Beats - 1));
   assign wbBeat     = (state == WB_DATA) && bus_wready_i && !bus_err_i;
   assign rdBeat     = (state == RD_DATA) && bus_rvalid_i && !bus_err_i;
   assign hasData    = !upgradeQ && !abortedQ;
   assign beatIdx    = int'(beat);
   assign missBase   = {missAddrQ[AddressSize-1:OffsetBits], {OffsetBits{1'b0}}};
   assign victimBase = {victimAddrQ[AddressSize-1:OffsetBits], {OffsetBits{1'b0}}};
   assign beatOffset = AddressSize'({beat, {ByteBits{1'b0}}});
   assign rdCmd      = writeQ ? BusRdX : BusRd;

   // Control state: FSM, beat counter, request flags, snoop and error history
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         beat       <= '0;
         writeQ     <= 1'b0;
         upgradeQ   <= 1'b0;
         sharedSeen <= 1'b0;
         abortedQ   <= 1'b0;
      end else begin
         state <= nextState;
         if (accept) begin
            beat       <= '0;
            writeQ     <= miss_write_i;
            upgradeQ   <= miss_upgrade_i;
            sharedSeen <= 1'b0;
            abortedQ   <= 1'b0;
         end else begin
            if (wbBeat || rdBeat) beat <= beat + BeatBits'(1);
            if (rdBeat)           sharedSeen <= sharedSeen | bus_shared_i;
            if (errAbort)         abortedQ <= 1'b1;
         end
      end
   end

   // Request addresses and victim line, captured once per accepted miss
   always_ff @(posedge clk) begin
      if (accept) begin
         missAddrQ   <= miss_addr_i;
         victimAddrQ <= victim_addr_i;
         victimDataQ <= victim_data_i;
      end
   end

   // Next-state: upgrade beats write-back, write-back precedes fetch, error aborts
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (miss_req_i) begin
               if (miss_upgrade_i)      nextState = UPG_REQ;
               else if (victim_dirty_i) nextState = WB_REQ;
               else                     nextState = RD_REQ;
            end
         end
         WB_REQ:   if (bus_gnt_i)               nextState = WB_DATA;
         WB_DATA:  if (bus_wready_i && lastBeat) nextState = RD_REQ;
         RD_REQ:   if (bus_gnt_i)               nextState = RD_DATA;
         RD_DATA:  if (bus_rvalid_i && lastBeat) nextState = DONE;
         UPG_REQ:  if (bus_gnt_i)               nextState = UPG_WAIT;
         UPG_WAIT: if (bus_ack_i)               nextState = DONE;
         DONE:                                  nextState = IDLE;
         default:                               nextState = IDLE;
      endcase
      if (errAbort) nextState = DONE;
   end

   // Outputs decoded from the current state only
   always_comb begin
      miss_busy_o     = (state != IDLE);
      miss_done_o     = 1'b0;
      fill_data_o     = '0;
      fill_state_o    = Invalid;
      fill_has_data_o = 1'b0;
      bus_req_o       = 1'b0;
      bus_cmd_o       = BusRd;
      bus_addr_o      = '0;
      bus_wdata_o     = '0;
      case (state)
         WB_REQ: begin
            bus_req_o  = 1'b1;
            bus_cmd_o  = BusWB;
            bus_addr_o = victimBase;
         end
         WB_DATA: begin
            bus_cmd_o   = BusWB;
            bus_addr_o  = victimBase | beatOffset;
            bus_wdata_o = victimDataQ[beatIdx*WordSize +: WordSize];
         end
         RD_REQ: begin
            bus_req_o  = 1'b1;
            bus_cmd_o  = rdCmd;
            bus_addr_o = missBase;
         end
         RD_DATA: begin
            bus_cmd_o  = rdCmd;
            bus_addr_o = missBase | beatOffset;
         end
         UPG_REQ: begin
            bus_req_o  = 1'b1;
            bus_cmd_o  = BusUpgr;
            bus_addr_o = missBase;
         end
         UPG_WAIT: begin
            bus_cmd_o  = BusUpgr;
            bus_addr_o = missBase;
         end
         DONE: begin
            miss_done_o     = 1'b1;
            fill_state_o    = finalStage(writeQ, upgradeQ, sharedSeen, abortedQ);
            fill_has_data_o = hasData;
            fill_data_o     = hasData ? lineData : '0;
         end
         default: ;
      endcase
   end

   dcache_line_buf #(
      .WordSize (WordSize),
      .Beats    (Beats)
   ) lineBuf (
      .clk    (clk),
      .rst    (rst),
      .clr    (accept),
      .wrEn   (rdBeat),
      .wrIdx  (beat),
      .wrData (bus_rdata_i),
      .line   (lineData)
   );

endmodule
